// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
// Package  : regfile_pkg
// Purpose  : Shared register-file constants, the write-arbiter state
//            encoding and a small sizing helper.
// Revision : 1.0 - initial release
// ============================================================================
package regfile_pkg;

  // Register file geometry: 16 registers addressed by a 4-bit index.
  localparam int REG_IDX_W = 4;
  localparam int NUM_REGS  = 16;

  // Index of the hard-wired zero register.
  localparam logic [REG_IDX_W-1:0] R0_IDX = '0;

  // Write-port arbiter states.
  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } arb_state_e;

  // Width of a requester index; a 1-wide index is kept even for a single
  // requester so that the vectors never collapse to zero width.
  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage : regfile_pkg
`default_nettype wire

// File: rtl/rr_priority_pick.sv
`default_nettype none
// ============================================================================
// Module   : rr_priority_pick
// Purpose  : Combinational round-robin picker. Starting at index ptr and
//            wrapping modulo NUM_REQ, returns the first asserted request.
//            Shared by the register-file write arbiter and read scheduler.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   req     in   NUM_REQ  request vector
//   ptr     in   PTR_W    index searched first (highest priority)
//   winner  out  PTR_W    index of the selected request (ptr when none)
//   valid   out  1        at least one request is asserted
// ============================================================================
module rr_priority_pick #(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [PTR_W-1:0]   winner,
  output logic               valid
);

  always_comb begin
    int base;
    int idx;
    winner = ptr;
    valid  = 1'b0;
    base   = int'(ptr);
    idx    = 0;
    // Walk offsets 0..NUM_REQ-1 from ptr; the first hit locks the result.
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (base + k) % NUM_REQ;
      if (!valid && req[idx[PTR_W-1:0]]) begin
        valid  = 1'b1;
        winner = idx[PTR_W-1:0];
      end
    end
  end

endmodule : rr_priority_pick
`default_nettype wire

// File: rtl/regfile_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : regfile_write_arbiter
// Purpose  : Round-robin arbiter sharing the single register-file write port
//            among NUM_REQ sources. The winning index/data are latched on the
//            IDLE->WRITE edge and presented for exactly one WRITE cycle
//            together with a one-hot grant back to the winner.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters:
//   NUM_REQ  number of requesters (2..8)
//   DATA_W   register data width
//   ZERO_R0  1: writes to R0 are granted but the write strobe is suppressed
// Ports:
//   clock     in   1               rising-edge clock
//   clear     in   1               synchronous active-high reset
//   req       in   NUM_REQ         level requests, held until granted
//   req_reg   in   4*NUM_REQ       destination index per requester
//   req_data  in   DATA_W*NUM_REQ  write data per requester
//   gnt       out  NUM_REQ         one-hot one-cycle grant
//   wr_sel    out  4               register index to the select decoder
//   wr_en     out  1               write strobe
//   wr_data   out  DATA_W          write data to the register file
//   busy      out  1               high while in WRITE
// ============================================================================
module regfile_write_arbiter
  import regfile_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 32,
  parameter bit ZERO_R0 = 1'b1
) (
  input  logic                        clock,
  input  logic                        clear,
  input  logic [NUM_REQ-1:0]          req,
  input  logic [REG_IDX_W*NUM_REQ-1:0] req_reg,
  input  logic [DATA_W*NUM_REQ-1:0]   req_data,
  output logic [NUM_REQ-1:0]          gnt,
  output logic [REG_IDX_W-1:0]        wr_sel,
  output logic                        wr_en,
  output logic [DATA_W-1:0]           wr_data,
  output logic                        busy
);

  localparam int PTR_W = ptr_width(NUM_REQ);
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_REQ - 1);

  arb_state_e state;
  arb_state_e state_next;

  logic [PTR_W-1:0]     ptr;
  logic [PTR_W-1:0]     winner_q;
  logic [REG_IDX_W-1:0] sel_q;
  logic [DATA_W-1:0]    data_q;

  logic [PTR_W-1:0]     pick_idx;
  logic                 pick_valid;
  logic [PTR_W-1:0]     ptr_next;
  logic                 take;

  // Per-requester views of the flattened request buses.
  logic [REG_IDX_W-1:0] reg_arr  [NUM_REQ];
  logic [DATA_W-1:0]    data_arr [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign reg_arr[i]  = req_reg[REG_IDX_W*i +: REG_IDX_W];
    assign data_arr[i] = req_data[DATA_W*i +: DATA_W];
  end

  rr_priority_pick #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_pick (
    .req    (req),
    .ptr    (ptr),
    .winner (pick_idx),
    .valid  (pick_valid)
  );

  // A new transaction is accepted only from IDLE; req is ignored in WRITE,
  // so a requester still holding req through its grant cycle is not
  // granted twice by the same arbitration.
  assign take = (state == IDLE) && pick_valid;

  // Rotate priority to the requester after the one just served.
  assign ptr_next = (winner_q == LAST_IDX) ? '0 : winner_q + PTR_W'(1);

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (clear) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic: a WRITE always lasts exactly one cycle.
  // --------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (pick_valid) state_next = WRITE;
      WRITE:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Transaction latches and round-robin pointer. Index and data are captured
  // only on the IDLE->WRITE edge, so later changes on the request buses do
  // not disturb the write in progress. They hold their value in IDLE.
  // --------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (clear) begin
      ptr      <= '0;
      winner_q <= '0;
      sel_q    <= R0_IDX;
      data_q   <= '0;
    end else begin
      if (take) begin
        winner_q <= pick_idx;
        sel_q    <= reg_arr[pick_idx];
        data_q   <= data_arr[pick_idx];
      end
      if (state == WRITE) begin
        ptr <= ptr_next;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Output decode: a function of flops only, never of req.
  // --------------------------------------------------------------------------
  always_comb begin
    busy    = (state == WRITE);
    gnt     = '0;
    if (busy) begin
      gnt[winner_q] = 1'b1;
    end
    // R0 writes still complete the handshake but must not disturb R0.
    wr_en   = busy && !(ZERO_R0 && (sel_q == R0_IDX));
    wr_sel  = sel_q;
    wr_data = data_q;
  end

endmodule : regfile_write_arbiter
`default_nettype wire

// File: tb/tb_regfile_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_write_arbiter
// Purpose  : Directed self-checking bench for regfile_write_arbiter. Two
//            instances share stimulus: one with ZERO_R0 = 1, one with 0.
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_write_arbiter;

  localparam int NR = 4;
  localparam int DW = 32;

  logic              clock;
  logic              clear;
  logic [NR-1:0]     req;
  logic [4*NR-1:0]   req_reg;
  logic [DW*NR-1:0]  req_data;

  logic [NR-1:0]     gnt,     gnt_nz;
  logic [3:0]        wr_sel,  wr_sel_nz;
  logic              wr_en,   wr_en_nz;
  logic [DW-1:0]     wr_data, wr_data_nz;
  logic              busy,    busy_nz;

  int checks;
  int errors;

  regfile_write_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .ZERO_R0(1'b1)) dut (
    .clock(clock), .clear(clear), .req(req), .req_reg(req_reg),
    .req_data(req_data), .gnt(gnt), .wr_sel(wr_sel), .wr_en(wr_en),
    .wr_data(wr_data), .busy(busy)
  );

  regfile_write_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .ZERO_R0(1'b0)) dut_nz (
    .clock(clock), .clear(clear), .req(req), .req_reg(req_reg),
    .req_data(req_data), .gnt(gnt_nz), .wr_sel(wr_sel_nz), .wr_en(wr_en_nz),
    .wr_data(wr_data_nz), .busy(busy_nz)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Requester i targets register i+1 with data 0x1000_0000 + i.
  task automatic set_defaults();
    req_reg  = 16'h4321;
    req_data = {32'h1000_0003, 32'h1000_0002, 32'h1000_0001, 32'h1000_0000};
  endtask

  task automatic do_reset();
    clear = 1'b1;
    req   = '0;
    set_defaults();
    repeat (2) @(negedge clock);
    clear = 1'b0;
  endtask

  task automatic test_reset();
    clear = 1'b1;
    req   = 4'b1111;
    set_defaults();
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      checks++;
      if (gnt !== 4'b0000 || wr_en !== 1'b0 || wr_sel !== 4'h0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold c%0d: gnt=%b wr_en=%b wr_sel=%h busy=%b want 0000 0 0 0",
                 c, gnt, wr_en, wr_sel, busy);
      end
    end
    checks++;
    if (wr_data !== 32'h0) begin
      errors++;
      $display("FAIL reset_data: got %h want 00000000", wr_data);
    end
    clear = 1'b0;
    @(negedge clock);
    checks++;
    if (gnt !== 4'b0001 || wr_sel !== 4'h1 || wr_data !== 32'h1000_0000 ||
        wr_en !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL reset_first_grant: gnt=%b sel=%h data=%h en=%b busy=%b want 0001 1 10000000 1 1",
               gnt, wr_sel, wr_data, wr_en, busy);
    end
    req = '0;
    @(negedge clock);
    checks++;
    if (gnt !== 4'b0000 || wr_en !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_after_grant: gnt=%b en=%b busy=%b want 0000 0 0", gnt, wr_en, busy);
    end
  endtask

  task automatic test_single();
    do_reset();
    req                = 4'b0100;
    req_reg[11:8]      = 4'hA;
    req_data[95:64]    = 32'hDEADBEEF;
    @(negedge clock);
    checks++;
    if (gnt !== 4'b0100 || wr_sel !== 4'hA || wr_en !== 1'b1 ||
        wr_data !== 32'hDEADBEEF || busy !== 1'b1) begin
      errors++;
      $display("FAIL single_write: gnt=%b sel=%h en=%b data=%h busy=%b want 0100 a 1 deadbeef 1",
               gnt, wr_sel, wr_en, wr_data, busy);
    end
    // Changing the source mid-write must not alter the presented write.
    req             = '0;
    req_reg[11:8]   = 4'h5;
    req_data[95:64] = 32'h0BAD_F00D;
    #1;
    checks++;
    if (wr_sel !== 4'hA || wr_data !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL single_stable: sel=%h data=%h want a deadbeef", wr_sel, wr_data);
    end
    @(negedge clock);
    checks++;
    if (gnt !== 4'b0000 || wr_en !== 1'b0 || busy !== 1'b0 || wr_sel !== 4'hA) begin
      errors++;
      $display("FAIL single_one_cycle: gnt=%b en=%b busy=%b sel=%h want 0000 0 0 a",
               gnt, wr_en, busy, wr_sel);
    end
    set_defaults();
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_gnt;
    int g;
    do_reset();
    req = 4'b1111;
    for (int c = 0; c < 16; c++) begin
      @(negedge clock);
      g       = (c / 2) % 4;
      exp_gnt = (c % 2 == 0) ? (4'b0001 << g) : 4'b0000;
      checks++;
      if (gnt !== exp_gnt) begin
        errors++;
        $display("FAIL rr_gnt c%0d: got %b want %b", c, gnt, exp_gnt);
      end
      if (c % 2 == 0) begin
        checks++;
        if (wr_sel !== 4'(g + 1) || wr_data !== 32'h1000_0000 + 32'(g) || wr_en !== 1'b1) begin
          errors++;
          $display("FAIL rr_write c%0d: sel=%h data=%h en=%b want %h %h 1",
                   c, wr_sel, wr_data, wr_en, 4'(g + 1), 32'h1000_0000 + 32'(g));
        end
      end
    end
    req = '0;
    @(negedge clock);
  endtask

  task automatic test_wrap_skip();
    do_reset();
    req = 4'b0100;
    @(negedge clock);
    checks++;
    if (gnt !== 4'b0100) begin
      errors++;
      $display("FAIL wrap_setup: gnt=%b want 0100", gnt);
    end
    req = 4'b0011;
    @(negedge clock);
    checks++;
    if (gnt !== 4'b0000) begin
      errors++;
      $display("FAIL wrap_gap: gnt=%b want 0000", gnt);
    end
    @(negedge clock);
    checks++;
    if (gnt !== 4'b0001 || wr_sel !== 4'h1) begin
      errors++;
      $display("FAIL wrap_grant0: gnt=%b sel=%h want 0001 1", gnt, wr_sel);
    end
    @(negedge clock);
    @(negedge clock);
    checks++;
    if (gnt !== 4'b0010 || wr_sel !== 4'h2) begin
      errors++;
      $display("FAIL wrap_ptr1: gnt=%b sel=%h want 0010 2", gnt, wr_sel);
    end
    req = '0;
    @(negedge clock);
  endtask

  task automatic test_r0_suppress();
    do_reset();
    req          = 4'b0010;
    req_reg[7:4] = 4'h0;
    @(negedge clock);
    checks++;
    if (gnt !== 4'b0010 || wr_en !== 1'b0 || busy !== 1'b1 || wr_sel !== 4'h0) begin
      errors++;
      $display("FAIL r0_zero: gnt=%b en=%b busy=%b sel=%h want 0010 0 1 0",
               gnt, wr_en, busy, wr_sel);
    end
    checks++;
    if (gnt_nz !== 4'b0010 || wr_en_nz !== 1'b1 || wr_sel_nz !== 4'h0 ||
        wr_data_nz !== 32'h1000_0001) begin
      errors++;
      $display("FAIL r0_nozero: gnt=%b en=%b sel=%h data=%h want 0010 1 0 10000001",
               gnt_nz, wr_en_nz, wr_sel_nz, wr_data_nz);
    end
    req = '0;
    set_defaults();
    @(negedge clock);
  endtask

  task automatic test_clear_mid();
    do_reset();
    req = 4'b0010;
    @(negedge clock);
    checks++;
    if (gnt !== 4'b0010 || busy !== 1'b1) begin
      errors++;
      $display("FAIL clr_setup: gnt=%b busy=%b want 0010 1", gnt, busy);
    end
    clear = 1'b1;
    req   = 4'b1111;
    for (int c = 0; c < 2; c++) begin
      @(negedge clock);
      checks++;
      if (gnt !== 4'b0000 || wr_en !== 1'b0 || busy !== 1'b0 ||
          wr_sel !== 4'h0 || wr_data !== 32'h0) begin
        errors++;
        $display("FAIL clr_abort c%0d: gnt=%b en=%b busy=%b sel=%h data=%h want all 0",
                 c, gnt, wr_en, busy, wr_sel, wr_data);
      end
    end
    clear = 1'b0;
    @(negedge clock);
    checks++;
    if (gnt !== 4'b0001 || wr_sel !== 4'h1) begin
      errors++;
      $display("FAIL clr_ptr0: gnt=%b sel=%h want 0001 1", gnt, wr_sel);
    end
    req = '0;
    @(negedge clock);
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    clear    = 1'b1;
    req      = '0;
    req_reg  = '0;
    req_data = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_wrap_skip();
    test_r0_suppress();
    test_clear_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_regfile_write_arbiter
`default_nettype wire

// File: doc/regfile_write_arbiter.md
# regfile_write_arbiter

Round-robin arbiter that shares the single register-file write port among NUM_REQ requesters (ALU writeback, memory load return, and similar sources). It latches the winning request's register index and data, then drives the 4-bit write select into the register-file 4-to-16 select decoder together with a one-cycle write enable. It returns a one-cycle grant to the winner. It sits between the execution/memory sources and the register file.

## Interface
- NUM_REQ, 4: number of requesters, 2..8.
- DATA_W, 32: register data width.
- ZERO_R0, 1: when 1, writes to R0 are granted but not performed.

- clock  in  1  system clock; all state updates on its rising edge.
- clear  in  1  synchronous, active-high reset.
- req  in  NUM_REQ  per-requester write request, level; held until gnt.
- req_reg  in  4*NUM_REQ  destination register index; requester i uses bits [4i+3:4i].
- req_data  in  DATA_W*NUM_REQ  write data; requester i uses bits [DATA_W*i+DATA_W-1:DATA_W*i].
- gnt  out  NUM_REQ  one-hot, one-cycle grant/acknowledge pulse.
- wr_sel  out  4  register index driven to the select decoder input.
- wr_en  out  1  write strobe gating the decoder outputs.
- wr_data  out  DATA_W  data to the register file.
- busy  out  1  high while in WRITE state.

## Operation
- Two states: IDLE and WRITE.
- IDLE: if req != 0, choose the winner by round-robin. The search starts at index ptr and wraps modulo NUM_REQ; the first set bit wins. Latch the winner index, req_reg slice, and req_data slice, then go to WRITE. If req == 0, stay in IDLE with all outputs unchanged except wr_en/gnt held at 0.
- WRITE:
  - Assert gnt[winner] = 1 and busy = 1.
  - wr_sel and wr_data come from the latched values.
  - wr_en = 1, except when ZERO_R0 = 1 and the latched index = 0, in which case wr_en = 0.
  - On exit: ptr <= (winner + 1) mod NUM_REQ; next state is unconditionally IDLE.
- The requester must drop req, or present a new request, in the cycle after gnt. The arbiter samples req again only in IDLE, so a stale req is never double-granted within the same WRITE.
- req_reg/req_data are sampled only at the IDLE→WRITE edge. Later changes to them do not affect the write in progress.
- Reset values: state = IDLE, ptr = 0, gnt = 0, wr_en = 0, busy = 0, wr_sel = 4'h0, wr_data = 0.
- clear has priority over every other event. Asserting it in WRITE aborts the write: outputs take reset values on the next edge, and no gnt or wr_en is produced after that edge.

## Timing
- All outputs are registered; there is no combinational path from req to any output.
- Latency: req sampled high in IDLE at edge N → gnt, wr_en, and wr_sel valid during cycle N+1 (one cycle wide).
- Throughput: at most one write every 2 cycles, achieved when requests are back-to-back.
- Fairness: with all NUM_REQ requesters continuously requesting, each receives exactly one grant every 2*NUM_REQ cycles.
- Pointer wrap: when winner = NUM_REQ-1, ptr becomes 0.
- Simultaneous requests: only one gnt bit is ever set; $onehot0(gnt) holds on every cycle.
- wr_en implies busy, and gnt != 0 iff busy.

## Structure
- Shared package regfile_pkg holds:
  - REG_IDX_W = 4 and NUM_REGS = 16.
  - The state enum {IDLE, WRITE}.
  - The R0 index constant.
- Natural sub-module: rr_priority_pick. It is combinational and takes req and ptr, producing the winner index and a valid flag, so it can be reused by the read-port scheduler.
- The FSM, the latches, and ptr stay in regfile_write_arbiter.

## Test plan
- Reset: hold clear for 3 cycles with req = 4'b1111 → gnt = 0, wr_en = 0, and wr_sel = 0 throughout. After release, the first grant goes to requester 0.
- Single request: req = 4'b0100, req_reg[11:8] = 4'hA, data 32'hDEADBEEF → one cycle later gnt = 4'b0100, wr_sel = 4'hA, wr_en = 1, wr_data = 32'hDEADBEEF, for exactly one cycle.
- Round-robin: req = 4'b1111 held for 16 cycles → grant order 0,1,2,3,0,1,2,3, one grant every 2 cycles.
- Wrap/skip: ptr = 3 (after a grant to 2), req = 4'b0011 → grant to 0, then ptr = 1.
- R0 suppression: ZERO_R0 = 1, requester 1 targets reg 0 → gnt = 4'b0010, wr_en = 0. With ZERO_R0 = 0 the same stimulus gives wr_en = 1 and wr_sel = 0.
- Reset mid-operation: assert clear during WRITE → next cycle gnt = 0, wr_en = 0, state IDLE, ptr = 0, and no register write is observed.
